// File: rtl/cc_rst_seq_if.sv
// Signal bundle between the config register block (master side) and the
// per-core reset sequencer (slave side).
// Optional status outputs exist only when CC_RST_STATUS_EN is defined.
interface cc_rst_seq_if;
  logic        cfg_rst_i;
  logic [31:0] cfg_boot_i;
  logic        core_idle_i;
  logic        core_rst_no;
  logic [31:0] boot_addr_o;
  logic        busy_o;
`ifdef CC_RST_STATUS_EN
  logic        drain_tmo_o;
  logic [7:0]  rst_cnt_o;
`endif

  modport master (
    output cfg_rst_i, cfg_boot_i, core_idle_i,
`ifdef CC_RST_STATUS_EN
    input  drain_tmo_o, rst_cnt_o,
`endif
    input  core_rst_no, boot_addr_o, busy_o
  );

  modport slave (
    input  cfg_rst_i, cfg_boot_i, core_idle_i,
`ifdef CC_RST_STATUS_EN
    output drain_tmo_o, rst_cnt_o,
`endif
    output core_rst_no, boot_addr_o, busy_o
  );
endinterface

// File: rtl/cc_rst_seq.sv
// Per-core reset sequencer: turns the software reset request and boot address
// into a clean active-low core reset with a minimum hold time, a boot-address
// setup window, and a bounded bus-drain phase before reset is applied to a
// running core.
// Optional feature macro: CC_RST_STATUS_EN adds drain_tmo_o (sticky drain
// timeout flag) and rst_cnt_o (count of resets applied to a running core).
module cc_rst_seq #(
  parameter int          HOLD_CYCLES   = 16,
  parameter int          SETUP_CYCLES  = 4,
  parameter int          DRAIN_TIMEOUT = 256,
  parameter logic [31:0] BOOT_RST_VAL  = 32'h0000_0000
) (
  input  logic        PCLK,
  input  logic        PRESET,
  cc_rst_seq_if.slave bus
);

  // One down-counter serves all three timed phases.
  localparam int CNT_MAX = (HOLD_CYCLES > SETUP_CYCLES)
                         ? ((HOLD_CYCLES > DRAIN_TIMEOUT) ? HOLD_CYCLES : DRAIN_TIMEOUT)
                         : ((SETUP_CYCLES > DRAIN_TIMEOUT) ? SETUP_CYCLES : DRAIN_TIMEOUT);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_SETUP,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_core_rst_n;
  logic [31:0]        r_boot_addr;
  logic               r_busy;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_core_rst_n_nxt;
  logic [31:0]        w_boot_addr_nxt;
  logic               w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  // Next-state, counter and output decode for the reset sequence.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_core_rst_n_nxt = r_core_rst_n;
    w_boot_addr_nxt  = r_boot_addr;

    unique case (r_state)
      ST_HOLD: begin
        w_core_rst_n_nxt = 1'b0;
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (!bus.cfg_rst_i) begin
          // Boot address is captured once, on entry to SETUP.
          w_boot_addr_nxt = bus.cfg_boot_i;
          w_cnt_nxt       = SETUP_LD;
          w_state_nxt     = ST_SETUP;
        end
      end

      ST_SETUP: begin
        w_core_rst_n_nxt = 1'b0;
        if (bus.cfg_rst_i) begin
          w_cnt_nxt   = HOLD_LD;
          w_state_nxt = ST_HOLD;
        end else if (w_cnt_zero) begin
          w_core_rst_n_nxt = 1'b1;
          w_state_nxt      = ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end

      ST_RUN: begin
        w_core_rst_n_nxt = 1'b1;
        if (bus.cfg_rst_i) begin
          w_cnt_nxt   = DRAIN_LD;
          w_state_nxt = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        w_core_rst_n_nxt = 1'b1;
        // A withdrawn request takes priority over idle/timeout.
        if (!bus.cfg_rst_i) begin
          w_state_nxt = ST_RUN;
        end else if (bus.core_idle_i || w_cnt_zero) begin
          w_core_rst_n_nxt = 1'b0;
          w_cnt_nxt        = HOLD_LD;
          w_state_nxt      = ST_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end

      default: begin
        w_core_rst_n_nxt = 1'b0;
        w_cnt_nxt        = HOLD_LD;
        w_state_nxt      = ST_HOLD;
      end
    endcase
  end

  // State, counter and registered outputs with synchronous reset.
  always_ff @(posedge PCLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    if (PRESET) begin
      r_state      <= ST_HOLD;
      r_cnt        <= HOLD_LD;
      r_core_rst_n <= 1'b0;
      r_boot_addr  <= BOOT_RST_VAL;
      r_busy       <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_core_rst_n <= w_core_rst_n_nxt;
      r_boot_addr  <= w_boot_addr_nxt;
      r_busy       <= (w_state_nxt != ST_RUN);
    end
  end

  assign bus.core_rst_no = r_core_rst_n;
  assign bus.boot_addr_o = r_boot_addr;
  assign bus.busy_o      = r_busy;

`ifdef CC_RST_STATUS_EN
  logic       r_drain_tmo;
  logic [7:0] r_rst_cnt;
  logic       w_drain_to_hold;

  // Only DRAIN can move a running core into HOLD outside of PRESET.
  assign w_drain_to_hold = (r_state == ST_DRAIN) && (w_state_nxt == ST_HOLD);

  // Sticky timeout flag and wrapping reset-entry counter.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_drain_tmo <= 1'b0;
      r_rst_cnt   <= 8'd0;
    end else if (w_drain_to_hold) begin
      r_rst_cnt <= r_rst_cnt + 8'd1;
      if (!bus.core_idle_i) begin
        r_drain_tmo <= 1'b1;
      end
    end
  end

  assign bus.drain_tmo_o = r_drain_tmo;
  assign bus.rst_cnt_o   = r_rst_cnt;
`endif

endmodule
